// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared parameters, FSM state type and write-enable helper for the
// 512x96 single-port SRAM access controller.
package ct_spsram_ctrl_pkg;

  localparam int ADDR_WIDTH = 9;
  localparam int DATA_WIDTH = 96;
  localparam int LANE_WIDTH = 24;
  localparam int NUM_LANES  = 4;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    RD_RSP = 2'd2
  } state_e;

  // SRAM WEN is active-low per bit: a set mask bit enables its whole lane.
  function automatic logic [DATA_WIDTH-1:0] lane_wen(input logic [NUM_LANES-1:0] mask);
    logic [DATA_WIDTH-1:0] wen;
    wen = '1;
    for (int i = 0; i < NUM_LANES; i++) begin
      wen[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{~mask[i]}};
    end
    return wen;
  endfunction

endpackage

// File: rtl/ct_f_spsram_512x96.sv
// Behavioural 512x96 single-port SRAM macro: active-low CEN/GWEN, per-bit
// active-low WEN, registered Q that only changes on a read.
module ct_f_spsram_512x96
  import ct_spsram_ctrl_pkg::*;
(
  input  logic                  CLK,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] q_q;

  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (GWEN) begin
        q_q <= mem_q[A];
      end else begin
        mem_q[A] <= (mem_q[A] & WEN) | (D & ~WEN);
      end
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/ct_spsram_512x96_acc_ctrl.sv
// Access controller for the 512x96 SRAM: zero-clear sweep after reset or on
// request, then single-port read/write with a held read response.
module ct_spsram_512x96_acc_ctrl
  import ct_spsram_ctrl_pkg::*;
(
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_LANES-1:0]  req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_pend_q, init_pend_d;

  logic                  req_acc;
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q;

  assign init_done = cpurst_b && (state_q != INIT);
  assign rsp_vld   = cpurst_b && (state_q == RD_RSP);
  assign rsp_rdata = sram_q;
  assign req_acc   = req_vld && req_ready;

  // A pending or fresh init request blocks the handshake-cycle request.
  always_comb begin
    req_ready = 1'b0;
    if (cpurst_b && !init_req) begin
      unique case (state_q)
        IDLE:    req_ready = 1'b1;
        RD_RSP:  req_ready = rsp_ready && !init_pend_q;
        default: req_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = req_addr;
    sram_d    = req_wdata;
    if (cpurst_b) begin
      if (state_q == INIT) begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = cnt_q;
        sram_d    = '0;
      end else if (req_acc) begin
        sram_cen  = 1'b0;
        sram_gwen = !req_wr;
        sram_wen  = req_wr ? lane_wen(req_wmask) : '1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_pend_d = init_pend_q;
    unique case (state_q)
      INIT: begin
        // Counter stops at the last address; it is cleared on INIT entry.
        if (&cnt_q) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (init_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end else if (req_acc && !req_wr) begin
          state_d = RD_RSP;
        end
      end
      RD_RSP: begin
        if (rsp_ready) begin
          if (init_req || init_pend_q) begin
            state_d     = INIT;
            cnt_d       = '0;
            init_pend_d = 1'b0;
          end else if (req_acc && !req_wr) begin
            state_d = RD_RSP;
          end else begin
            state_d = IDLE;
          end
        end else if (init_req) begin
          init_pend_d = 1'b1;
        end
      end
      default: begin
        state_d     = INIT;
        cnt_d       = '0;
        init_pend_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_pend_q <= init_pend_d;
    end
  end

  ct_f_spsram_512x96 u_sram (
    .CLK  (forever_cpuclk),
    .CEN  (sram_cen),
    .GWEN (sram_gwen),
    .WEN  (sram_wen),
    .A    (sram_a),
    .D    (sram_d),
    .Q    (sram_q)
  );

endmodule
